tcu_print_rx: RTL and testbench

Receive-side companion to the TCU print controller. It sits in the I/O/host module at the NoC write-port endpoint addressed by the print chip/module ID. It accepts print packets (single non-burst writes, or burst header plus payload flits) and unpacks them into an in-order byte stream with a valid/ready handshake, e.g. towards a UART TX FIFO or a simulation console. Malformed packets raise a one-cycle error pulse and never lock up the block.

---
 rtl/tcu_print_rx.sv | 142 ++++++++++++++
 tb/tb_tcu_print_rx.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcu_print_rx.sv
// Receive side of the TCU print path: decodes NoC print packets (non-burst writes or
// burst header + payload flits) into an in-order byte stream with a valid/ready handshake.
module tcu_print_rx #(
    parameter int NOC_DATA_SIZE       = 64,
    parameter int NOC_BSEL_SIZE       = 16,
    parameter int PRINT_FLIT_CNT_SIZE = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     noc_wrreq_i,
    input  logic                     noc_burst_i,
    input  logic [NOC_BSEL_SIZE-1:0] noc_bsel_i,
    input  logic [NOC_DATA_SIZE-1:0] noc_data0_i,
    input  logic [NOC_DATA_SIZE-1:0] noc_data1_i,
    output logic                     noc_stall_o,
    output logic                     byte_valid_o,
    output logic [7:0]               byte_data_o,
    input  logic                     byte_ready_i,
    output logic                     rx_active_o,
    output logic                     rx_err_o
);

    typedef enum logic {S_IDLE, S_PAYLOAD} state_t;

    state_t                         state, state_next;
    logic [PRINT_FLIT_CNT_SIZE-1:0] flit_cnt, flit_cnt_next;
    logic [3:0]                     last_idx, last_idx_next;
    logic [7:0]                     buf_q [16];
    logic [4:0]                     buf_cnt, buf_cnt_next;
    logic [3:0]                     rd_ptr;
    logic                           stall_q;
    logic                           err_q, err_next;
    logic                           accept, xfer, load_en;
    logic [4:0]                     load_cnt;
    logic [4:0]                     nb_len;
    logic                           nb_run;
    logic [2*NOC_DATA_SIZE-1:0]     payload;
    logic                           unused_bits;

    assign accept       = noc_wrreq_i && !stall_q;
    assign byte_valid_o = (buf_cnt != 5'd0);
    assign xfer         = byte_valid_o && byte_ready_i;
    assign payload      = {noc_data1_i, noc_data0_i};
    assign unused_bits  = ^{noc_bsel_i[NOC_BSEL_SIZE-1:12], noc_data0_i[NOC_DATA_SIZE-1:PRINT_FLIT_CNT_SIZE]};

    // Non-burst length: run of set bits in bsel[7:0] starting at bit 0.
    always_comb begin
        nb_len = 5'd0;
        nb_run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (nb_run && noc_bsel_i[i]) nb_len = nb_len + 5'd1;
            else                         nb_run = 1'b0;
        end
    end

    always_comb begin
        state_next    = state;
        flit_cnt_next = flit_cnt;
        last_idx_next = last_idx;
        load_en       = 1'b0;
        load_cnt      = 5'd0;
        err_next      = 1'b0;
        if (accept) begin
            case (state)
                S_IDLE: begin
                    if (!noc_burst_i) begin
                        if (!noc_bsel_i[0]) begin
                            err_next = 1'b1;
                        end else begin
                            load_en  = 1'b1;
                            load_cnt = nb_len;
                        end
                    end else begin
                        flit_cnt_next = noc_data0_i[PRINT_FLIT_CNT_SIZE-1:0];
                        last_idx_next = noc_bsel_i[11:8];
                        if (noc_data0_i[PRINT_FLIT_CNT_SIZE-1:0] == '0) err_next   = 1'b1;
                        else                                             state_next = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    flit_cnt_next = flit_cnt - PRINT_FLIT_CNT_SIZE'(1);
                    load_en       = 1'b1;
                    // A burst/count disagreement always closes the packet so the block cannot wedge.
                    if (flit_cnt == PRINT_FLIT_CNT_SIZE'(1)) begin
                        state_next = S_IDLE;
                        if (noc_burst_i) begin
                            err_next = 1'b1;
                            load_cnt = 5'd16;
                        end else begin
                            load_cnt = {1'b0, last_idx} + 5'd1;
                        end
                    end else if (noc_burst_i) begin
                        load_cnt = 5'd16;
                    end else begin
                        err_next   = 1'b1;
                        load_cnt   = {1'b0, last_idx} + 5'd1;
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        buf_cnt_next = buf_cnt;
        if (load_en)   buf_cnt_next = load_cnt;
        else if (xfer) buf_cnt_next = buf_cnt - 5'd1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= S_IDLE;
            flit_cnt <= '0;
            last_idx <= 4'd0;
            buf_cnt  <= 5'd0;
            rd_ptr   <= 4'd0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < 16; i++) buf_q[i] <= 8'h00;
        end else begin
            state    <= state_next;
            flit_cnt <= flit_cnt_next;
            last_idx <= last_idx_next;
            buf_cnt  <= buf_cnt_next;
            stall_q  <= (buf_cnt_next != 5'd0);
            err_q    <= err_next;
            if (load_en) begin
                rd_ptr <= 4'd0;
                for (int i = 0; i < 16; i++) buf_q[i] <= payload[8*i +: 8];
            end else if (xfer) begin
                rd_ptr <= rd_ptr + 4'd1;
            end
        end
    end

    assign noc_stall_o = stall_q;
    assign byte_data_o = buf_q[rd_ptr];
    assign rx_active_o = (state == S_PAYLOAD) || byte_valid_o;
    assign rx_err_o    = err_q;

endmodule

// File: tb/tb_tcu_print_rx.sv
// Self-checking bench for tcu_print_rx: directed packet scenarios plus randomized packet
// streams compared against a packet-level model of the expected byte stream and error count.
module tb_tcu_print_rx;

    logic        clk_i;
    logic        reset_n_i;
    logic        noc_wrreq_i;
    logic        noc_burst_i;
    logic [15:0] noc_bsel_i;
    logic [63:0] noc_data0_i;
    logic [63:0] noc_data1_i;
    logic        noc_stall_o;
    logic        byte_valid_o;
    logic [7:0]  byte_data_o;
    logic        byte_ready_i;
    logic        rx_active_o;
    logic        rx_err_o;

    int          tests_run;
    int          tests_failed;
    int          err_seen;
    int          ready_mode;
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];
    logic        hold;
    logic [7:0]  hold_data;

    tcu_print_rx dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .noc_wrreq_i  (noc_wrreq_i),
        .noc_burst_i  (noc_burst_i),
        .noc_bsel_i   (noc_bsel_i),
        .noc_data0_i  (noc_data0_i),
        .noc_data1_i  (noc_data1_i),
        .noc_stall_o  (noc_stall_o),
        .byte_valid_o (byte_valid_o),
        .byte_data_o  (byte_data_o),
        .byte_ready_i (byte_ready_i),
        .rx_active_o  (rx_active_o),
        .rx_err_o     (rx_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Sink ready pattern: 0 = always ready, 1 = toggling, 2 = random, 3 = never ready.
    initial begin
        byte_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (ready_mode)
                0:       byte_ready_i = 1'b1;
                1:       byte_ready_i = ~byte_ready_i;
                2:       byte_ready_i = 1'($urandom_range(0, 1));
                default: byte_ready_i = 1'b0;
            endcase
        end
    end

    // Byte sink / monitor: records transfers, counts error cycles, checks hold-while-stalled.
    initial begin
        hold = 1'b0;
        hold_data = 8'h00;
        forever begin
            @(negedge clk_i);
            if (!reset_n_i) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    tests_run++;
                    if (byte_valid_o !== 1'b1 || byte_data_o !== hold_data) begin
                        tests_failed++;
                        $display("[TB] FAIL hold_stable: valid=%b data=%h required valid=1 data=%h",
                                 byte_valid_o, byte_data_o, hold_data);
                    end
                end
                if (rx_err_o === 1'b1) err_seen++;
                if (byte_valid_o === 1'b1 && byte_ready_i === 1'b1) rx_q.push_back(byte_data_o);
                hold      = (byte_valid_o === 1'b1) && (byte_ready_i === 1'b0);
                hold_data = byte_data_o;
            end
        end
    end

    // Drive one flit and hold it until the block accepts it; waited = stalled cycles.
    task automatic send_flit(input logic burst, input logic [15:0] bsel,
                             input logic [63:0] d0, input logic [63:0] d1, output int waited);
        waited = 0;
        @(negedge clk_i);
        noc_wrreq_i = 1'b1;
        noc_burst_i = burst;
        noc_bsel_i  = bsel;
        noc_data0_i = d0;
        noc_data1_i = d1;
        while (noc_stall_o !== 1'b0 && waited < 300) begin
            @(negedge clk_i);
            waited++;
        end
        if (waited >= 300) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL flit_accept_timeout: stall=%b after %0d cycles, required 0", noc_stall_o, waited);
        end
        @(posedge clk_i);
        #1;
        noc_wrreq_i = 1'b0;
        noc_burst_i = 1'b0;
        noc_bsel_i  = 16'h0000;
        noc_data0_i = 64'h0;
        noc_data1_i = 64'h0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_i);
        while (rx_active_o !== 1'b0 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 400) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain_timeout: rx_active=%b, required 0", rx_active_o);
        end
        repeat (2) @(negedge clk_i);
    endtask

    // Model: bytes a non-burst print delivers (run of ones in bsel[7:0] from bit 0).
    function automatic int model_nb_len(input logic [15:0] bsel);
        int n;
        n = 0;
        while (n < 8 && bsel[n]) n++;
        return n;
    endfunction

    task automatic push_exp(input logic [63:0] d0, input logic [63:0] d1, input int n);
        logic [127:0] p;
        p = {d1, d0};
        for (int i = 0; i < n; i++) exp_q.push_back(p[8*i +: 8]);
    endtask

    task automatic test_reset();
        reset_n_i   = 1'b0;
        noc_wrreq_i = 1'b0;
        noc_burst_i = 1'b0;
        noc_bsel_i  = 16'h0000;
        noc_data0_i = 64'h0;
        noc_data1_i = 64'h0;
        #12;
        tests_run++;
        if ({noc_stall_o, byte_valid_o, byte_data_o, rx_active_o, rx_err_o} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: stall=%b valid=%b data=%h active=%b err=%b required all 0",
                     noc_stall_o, byte_valid_o, byte_data_o, rx_active_o, rx_err_o);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        tests_run++;
        if ({noc_stall_o, byte_valid_o, rx_active_o, rx_err_o} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_idle: stall=%b valid=%b active=%b err=%b required 0",
                     noc_stall_o, byte_valid_o, rx_active_o, rx_err_o);
        end
    endtask

    task automatic test_hello();
        logic [7:0] hello [5];
        int w, e0;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        ready_mode = 0;
        rx_q.delete();
        e0 = err_seen;
        send_flit(1'b0, 16'h001F, 64'h0000004F4C4C4548, {$urandom, $urandom}, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            tests_run++;
            if ({noc_stall_o, byte_valid_o, byte_data_o} !== {1'b1, 1'b1, hello[i]}) begin
                tests_failed++;
                $display("[TB] FAIL hello_cycle%0d: stall=%b valid=%b data=%h required 1 1 %h",
                         i + 1, noc_stall_o, byte_valid_o, byte_data_o, hello[i]);
            end
        end
        @(negedge clk_i);
        tests_run++;
        if ({noc_stall_o, byte_valid_o} !== 2'b00 || rx_q.size() != 5 || err_seen != e0) begin
            tests_failed++;
            $display("[TB] FAIL hello_done: stall=%b valid=%b bytes=%0d errs=%0d required 0 0 5 0",
                     noc_stall_o, byte_valid_o, rx_q.size(), err_seen - e0);
        end
        rx_q.delete();
    endtask

    task automatic test_burst20();
        int w, e0, bad;
        ready_mode = 0;
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
        e0 = err_seen;
        send_flit(1'b1, 16'h03FF, 64'd2, {$urandom, $urandom}, w);
        send_flit(1'b1, 16'($urandom), 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, w);
        tests_run++;
        if (w != 0) begin
            tests_failed++;
            $display("[TB] FAIL header_no_stall: first payload waited %0d cycles, required 0", w);
        end
        send_flit(1'b0, 16'($urandom), {32'($urandom), 32'h13121110}, {$urandom, $urandom}, w);
        tests_run++;
        if (rx_q.size() != 16) begin
            tests_failed++;
            $display("[TB] FAIL burst20_flit2_stalled: %0d bytes out at flit2 accept, required 16", rx_q.size());
        end
        wait_idle();
        bad = -1;
        if (rx_q.size() == exp_q.size())
            for (int i = 0; i < rx_q.size(); i++) if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
        tests_run++;
        if (rx_q.size() != exp_q.size() || bad >= 0 || err_seen != e0) begin
            tests_failed++;
            $display("[TB] FAIL burst20_stream: bytes=%0d first_bad=%0d errs=%0d required 20 -1 0",
                     rx_q.size(), bad, err_seen - e0);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_burst32();
        int w, bad;
        logic [63:0] a0, a1, b0, b1;
        a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
        b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        ready_mode = 0;
        rx_q.delete();
        exp_q.delete();
        push_exp(a0, a1, 16);
        push_exp(b0, b1, 16);
        send_flit(1'b1, 16'h0FFF, 64'd2, 64'h0, w);
        send_flit(1'b1, 16'($urandom), a0, a1, w);
        send_flit(1'b0, 16'($urandom), b0, b1, w);
        repeat (16) @(negedge clk_i);
        tests_run++;
        if (rx_active_o !== 1'b1 || byte_valid_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL burst32_last_byte: active=%b valid=%b required 1 1", rx_active_o, byte_valid_o);
        end
        @(negedge clk_i);
        tests_run++;
        if (rx_active_o !== 1'b0 || noc_stall_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL burst32_idle: active=%b stall=%b required 0 0", rx_active_o, noc_stall_o);
        end
        bad = -1;
        if (rx_q.size() == exp_q.size())
            for (int i = 0; i < rx_q.size(); i++) if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
        tests_run++;
        if (rx_q.size() != 32 || bad >= 0) begin
            tests_failed++;
            $display("[TB] FAIL burst32_stream: bytes=%0d first_bad=%0d required 32 -1", rx_q.size(), bad);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int w;
        ready_mode = 1;
        rx_q.delete();
        send_flit(1'b0, 16'hA01F, 64'h0000004F4C4C4548, {$urandom, $urandom}, w);
        wait_idle();
        ready_mode = 0;
        tests_run++;
        if (rx_q.size() != 5 || {rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4]} !== 40'h48454C4C4F) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_stream: bytes=%0d required 5 bytes 48 45 4C 4C 4F", rx_q.size());
        end
        rx_q.delete();
    endtask

    task automatic test_errors();
        int w, e0, bad;
        logic [63:0] a0, a1, b0, b1;
        ready_mode = 0;
        rx_q.delete();
        exp_q.delete();
        e0 = err_seen;
        send_flit(1'b1, 16'($urandom), {32'($urandom), 32'h00000000}, 64'h0, w);
        repeat (3) @(negedge clk_i);
        tests_run++;
        if (err_seen != e0 + 1 || rx_active_o !== 1'b0 || rx_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL err_zero_header: errs=%0d active=%b bytes=%0d required 1 0 0",
                     err_seen - e0, rx_active_o, rx_q.size());
        end
        e0 = err_seen;
        send_flit(1'b0, 16'h00FE, {$urandom, $urandom}, 64'h0, w);
        repeat (3) @(negedge clk_i);
        tests_run++;
        if (err_seen != e0 + 1 || noc_stall_o !== 1'b0 || rx_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL err_nonburst_bsel: errs=%0d stall=%b bytes=%0d required 1 0 0",
                     err_seen - e0, noc_stall_o, rx_q.size());
        end
        a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
        b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        push_exp(a0, a1, 16);
        push_exp(b0, b1, 6);
        push_exp(64'h0000004F4C4C4548, 64'h0, 5);
        e0 = err_seen;
        send_flit(1'b1, 16'h0500, 64'd3, 64'h0, w);
        send_flit(1'b1, 16'h0000, a0, a1, w);
        send_flit(1'b0, 16'h0000, b0, b1, w);
        send_flit(1'b0, 16'h001F, 64'h0000004F4C4C4548, 64'h0, w);
        wait_idle();
        bad = -1;
        if (rx_q.size() == exp_q.size())
            for (int i = 0; i < rx_q.size(); i++) if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
        tests_run++;
        if (rx_q.size() != 27 || bad >= 0 || err_seen != e0 + 1) begin
            tests_failed++;
            $display("[TB] FAIL err_early_final: bytes=%0d first_bad=%0d errs=%0d required 27 -1 1",
                     rx_q.size(), bad, err_seen - e0);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_drain();
        int w, n, e0;
        ready_mode = 3;
        rx_q.delete();
        send_flit(1'b1, 16'h0F00, 64'd1, 64'h0, w);
        send_flit(1'b0, 16'h0000, {$urandom, $urandom}, {$urandom, $urandom}, w);
        ready_mode = 0;
        n = 0;
        while (rx_q.size() < 3 && n < 50) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        ready_mode = 3;
        @(negedge clk_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        tests_run++;
        if ({byte_valid_o, noc_stall_o, rx_active_o, byte_data_o} !== 11'h000 || rx_q.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_drain: valid=%b stall=%b active=%b data=%h drained=%0d required 0 0 0 00 3",
                     byte_valid_o, noc_stall_o, rx_active_o, byte_data_o, rx_q.size());
        end
        #10;
        reset_n_i = 1'b1;
        ready_mode = 0;
        rx_q.delete();
        e0 = err_seen;
        send_flit(1'b0, 16'h001F, 64'h0000004F4C4C4548, 64'h0, w);
        wait_idle();
        tests_run++;
        if (rx_q.size() != 5 || {rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4]} !== 40'h48454C4C4F
            || err_seen != e0) begin
            tests_failed++;
            $display("[TB] FAIL hello_after_reset: bytes=%0d errs=%0d required 5 bytes 48454C4C4F and 0 errs",
                     rx_q.size(), err_seen - e0);
        end
        rx_q.delete();
    endtask

    task automatic test_random();
        int w, e0, exp_err, nflits, li, bad;
        logic [15:0] bsel;
        logic [63:0] d0, d1;
        ready_mode = 2;
        rx_q.delete();
        exp_q.delete();
        e0 = err_seen;
        exp_err = 0;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 1) == 0) begin
                bsel = 16'($urandom);
                if ($urandom_range(0, 4) != 0) bsel[0] = 1'b1;
                d0 = {$urandom, $urandom};
                if (!bsel[0]) exp_err++;
                else push_exp(d0, 64'h0, model_nb_len(bsel));
                send_flit(1'b0, bsel, d0, {$urandom, $urandom}, w);
            end else begin
                nflits = $urandom_range(1, 3);
                li     = $urandom_range(0, 15);
                bsel   = {4'($urandom), 4'(li), 8'($urandom)};
                send_flit(1'b1, bsel, {48'({$urandom, $urandom}), 16'(nflits)}, {$urandom, $urandom}, w);
                for (int f = 1; f <= nflits; f++) begin
                    d0 = {$urandom, $urandom};
                    d1 = {$urandom, $urandom};
                    push_exp(d0, d1, (f == nflits) ? li + 1 : 16);
                    send_flit(f != nflits, 16'($urandom), d0, d1, w);
                end
            end
        end
        wait_idle();
        ready_mode = 0;
        bad = -1;
        if (rx_q.size() == exp_q.size())
            for (int i = 0; i < rx_q.size(); i++) if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
        tests_run++;
        if (rx_q.size() != exp_q.size() || bad >= 0) begin
            tests_failed++;
            $display("[TB] FAIL random_stream: bytes=%0d first_bad=%0d required %0d -1",
                     rx_q.size(), bad, exp_q.size());
        end
        tests_run++;
        if (err_seen - e0 != exp_err) begin
            tests_failed++;
            $display("[TB] FAIL random_errors: errs=%0d required %0d", err_seen - e0, exp_err);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        err_seen     = 0;
        ready_mode   = 0;
        test_reset();
        test_hello();
        test_burst20();
        test_burst32();
        test_backpressure();
        test_errors();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
